id_issue_stage: RTL

Decode-stage pipeline register and issue controller. It sits between the IF stage and the EXE stage, and holds one decoded instruction. It presents that instruction's source-register fields to the wake-up logic and consumes the returned src_1_ready/src_2_ready. It issues the instruction to EXE only when both operands are ready and EXE can accept it, and handles branch flush. It also keeps stall statistics and a hang watchdog.

---
 rtl/id_issue_stage.sv | 68 ++++++
 1 files changed

// File: rtl/id_issue_stage.sv
// id_issue_stage: decode-stage pipeline register with operand-ready issue control,
// branch flush, saturating stall statistics and a sticky hang watchdog.
module id_issue_stage #(
  parameter int PAYLOAD_WD = 64,
  parameter int CNT_WD     = 16,
  parameter int HANG_LIMIT = 1024
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  IF_to_ID_valid,
  input  logic [PAYLOAD_WD-1:0] IF_to_ID_payload,
  output logic                  ID_allowin,
  output logic [PAYLOAD_WD-1:0] ID_payload,
  output logic                  ID_valid,
  input  logic                  src_1_ready,
  input  logic                  src_2_ready,
  input  logic                  flush,
  input  logic                  EXE_allowin,
  output logic                  ID_to_EXE_valid,
  output logic [PAYLOAD_WD-1:0] ID_to_EXE_payload,
  output logic [CNT_WD-1:0]     stall_cnt,
  output logic                  hang
);
  localparam int HW = $clog2(HANG_LIMIT + 1);
  localparam logic [HW-1:0] HANG_MAX = HW'(HANG_LIMIT);
  typedef enum logic [1:0] {EMPTY, WAIT, READY} state_t;
  state_t                  w_state;
  logic                    r_valid;
  logic [PAYLOAD_WD-1:0]   r_payload;
  logic [CNT_WD-1:0]       r_stall_cnt;
  logic [HW-1:0]           r_wait_run;
  logic                    r_hang;
  logic                    w_ready_go;
  logic                    w_wait;
  logic                    w_load;
  logic [HW-1:0]           w_wait_nxt;
  // state is derived, not stored: it follows the held valid bit and live operand readiness
  always_comb begin
    w_ready_go = src_1_ready & src_2_ready;
    w_state    = !r_valid ? EMPTY : w_ready_go ? READY : WAIT;
    w_wait     = (w_state == WAIT) && !flush;
    w_wait_nxt = !w_wait ? '0 : (r_wait_run == HANG_MAX) ? r_wait_run : r_wait_run + HW'(1);
    w_load     = !flush && ID_allowin && IF_to_ID_valid;
  end
  assign ID_allowin        = ~r_valid | (w_ready_go & EXE_allowin);
  assign ID_to_EXE_valid   = r_valid & w_ready_go & ~flush;
  assign ID_valid          = r_valid;
  assign ID_payload        = r_payload;
  assign ID_to_EXE_payload = r_payload;
  assign stall_cnt         = r_stall_cnt;
  assign hang              = r_hang;
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_valid     <= 1'b0;
      r_payload   <= '0;
      r_stall_cnt <= '0;
      r_wait_run  <= '0;
      r_hang      <= 1'b0;
    end else begin
      if (flush) r_valid <= 1'b0;
      else if (ID_allowin) r_valid <= IF_to_ID_valid;
      if (w_load) r_payload <= IF_to_ID_payload;
      if (w_wait && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + CNT_WD'(1);
      r_wait_run <= w_wait_nxt;
      if (w_wait_nxt == HANG_MAX) r_hang <= 1'b1;
    end
  end
endmodule
